// File: rtl/sdf_stage_ctrl.sv
// Sequencing controller for one radix-2 SDF FFT stage: butterfly mode,
// twiddle index, output-valid and frame markers derived from a streaming input-valid.
module sdf_stage_ctrl #(
    parameter int N     = 32,
    parameter int DELAY = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic [1:0]             state,
    output logic [$clog2(N/2)-1:0] tw_idx,
    output logic                   out_valid,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   frame_err
);
    localparam int CW       = (DELAY > 1) ? $clog2(DELAY) : 1;
    localparam int TW_SHIFT = $clog2(N / (2 * DELAY));
    localparam int TWW      = $clog2(N / 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(DELAY - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        FIRST   = 2'b01,
        SECOND  = 2'b10,
        WAITING = 2'b11
    } state_t;

    state_t          r_st;
    logic [CW-1:0]   r_cnt;
    logic            r_more;
    logic            r_err;

    logic            w_last;
    logic            w_check;
    logic            w_expValid;
    logic            w_mismatch;
    logic [TWW-1:0]  w_tw;

    assign w_last = (r_cnt == CNT_LAST);
    assign w_tw   = TWW'(r_cnt) << TW_SHIFT;

    // The last FIRST cycle and a draining last SECOND cycle accept either in_valid value.
    always_comb begin
        w_check    = 1'b0;
        w_expValid = 1'b0;
        case (r_st)
            WAITING: begin
                w_check    = 1'b1;
                w_expValid = 1'b1;
            end
            FIRST: begin
                w_check    = !w_last;
                w_expValid = 1'b1;
            end
            SECOND: begin
                w_check    = r_more || !w_last;
                w_expValid = r_more;
            end
            default: begin
                w_check    = 1'b0;
                w_expValid = 1'b0;
            end
        endcase
    end

    assign w_mismatch = w_check && (in_valid != w_expValid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st   <= IDLE;
            r_cnt  <= '0;
            r_more <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_err <= w_mismatch;
            case (r_st)
                IDLE: begin
                    r_cnt <= '0;
                    if (in_valid) begin
                        r_st <= WAITING;
                    end
                end
                WAITING: begin
                    if (w_last) begin
                        r_st  <= FIRST;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                FIRST: begin
                    if (w_last) begin
                        r_st   <= SECOND;
                        r_cnt  <= '0;
                        r_more <= in_valid;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                SECOND: begin
                    if (w_last) begin
                        r_cnt <= '0;
                        if (r_more) begin
                            r_st <= FIRST;
                        end else if (in_valid) begin
                            r_st <= WAITING;
                        end else begin
                            r_st <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_st  <= IDLE;
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign state      = r_st;
    assign busy       = (r_st != IDLE);
    assign out_valid  = (r_st == FIRST) || (r_st == SECOND);
    assign tw_idx     = (r_st == SECOND) ? w_tw : '0;
    assign frame_done = (r_st == SECOND) && w_last && !r_more;
    assign frame_err  = r_err;

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// Bench for sdf_stage_ctrl: three instances (DELAY 16, 4, 1) checked every cycle
// against a stream-position model, plus hand-computed literal expectations.
module tb_sdf_stage_ctrl;
    localparam int DLY [3] = '{16, 4, 1};
    localparam int SHF [3] = '{0, 2, 4};

    typedef struct packed {
        logic [1:0] st;
        logic [3:0] tw;
        logic       ov;
        logic       bz;
        logic       fd;
        logic       fe;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       iv   [3];
    logic [1:0] st   [3];
    logic [3:0] tw   [3];
    logic       ov   [3];
    logic       bz   [3];
    logic       fd   [3];
    logic       fe   [3];

    int nTests = 0;
    int nFail  = 0;

    // Model: mPos = cycles since the stream's first in_valid (0 = idle),
    // mEnd = position of the final drain SECOND cycle once known (-1 = not yet).
    int   mPos [3];
    int   mEnd [3];
    logic mErr [3];

    sdf_stage_ctrl #(.N(32), .DELAY(16)) u_d16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .state(st[0]), .tw_idx(tw[0]),
        .out_valid(ov[0]), .busy(bz[0]), .frame_done(fd[0]), .frame_err(fe[0])
    );
    sdf_stage_ctrl #(.N(32), .DELAY(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .state(st[1]), .tw_idx(tw[1]),
        .out_valid(ov[1]), .busy(bz[1]), .frame_done(fd[1]), .frame_err(fe[1])
    );
    sdf_stage_ctrl #(.N(32), .DELAY(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .state(st[2]), .tw_idx(tw[2]),
        .out_valid(ov[2]), .busy(bz[2]), .frame_done(fd[2]), .frame_err(fe[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t modelOut(input int i);
        exp_t e;
        int   d, off, blk;
        d = DLY[i];
        e = '0;
        e.fe = mErr[i];
        if (mPos[i] != 0) begin
            e.bz = 1'b1;
            if (mPos[i] <= d) begin
                e.st = 2'b11;
            end else begin
                off  = (mPos[i] - d - 1) % d;
                blk  = (mPos[i] - d - 1) / d;
                e.ov = 1'b1;
                if (blk % 2 == 0) begin
                    e.st = 2'b01;
                end else begin
                    e.st = 2'b10;
                    e.tw = 4'(off << SHF[i]);
                end
            end
            e.fd = (mPos[i] == mEnd[i]);
        end
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                mPos[i] <= 0;
                mEnd[i] <= -1;
                mErr[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin : step
                int   p, e, d, off, blk, np, ne;
                logic er;
                p  = mPos[i];
                e  = mEnd[i];
                d  = DLY[i];
                er = 1'b0;
                np = p;
                ne = e;
                if (p == 0) begin
                    np = iv[i] ? 1 : 0;
                    ne = -1;
                end else begin
                    if (p <= d) begin
                        er = !iv[i];
                    end else begin
                        off = (p - d - 1) % d;
                        blk = (p - d - 1) / d;
                        if (blk % 2 == 0) begin
                            if (off < d - 1) er = !iv[i];
                            else if (!iv[i]) ne = p + d;
                        end else begin
                            if (e < 0) er = !iv[i];
                            else if (off < d - 1) er = iv[i];
                        end
                    end
                    if (p == e) begin
                        np = iv[i] ? 1 : 0;
                        ne = -1;
                    end else begin
                        np = p + 1;
                    end
                end
                mPos[i] <= np;
                mEnd[i] <= ne;
                mErr[i] <= er;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of all three instances against the model.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                e = modelOut(i);
                checkOutput($sformatf("d%0d.state", DLY[i]), 32'(st[i]), 32'(e.st));
                checkOutput($sformatf("d%0d.tw_idx", DLY[i]), 32'(tw[i]), 32'(e.tw));
                checkOutput($sformatf("d%0d.out_valid", DLY[i]), 32'(ov[i]), 32'(e.ov));
                checkOutput($sformatf("d%0d.busy", DLY[i]), 32'(bz[i]), 32'(e.bz));
                checkOutput($sformatf("d%0d.frame_done", DLY[i]), 32'(fd[i]), 32'(e.fd));
                checkOutput($sformatf("d%0d.frame_err", DLY[i]), 32'(fe[i]), 32'(e.fe));
            end
        end
    end

    function automatic logic ivFor(input int s, input int i, input int k);
        logic v;
        v = 1'b0;
        case (i)
            0: case (s)
                   1, 5: v = (k < 32);
                   2:    v = (k < 64);
                   3:    v = (k < 32) && (k != 5);
                   4:    v = (k < 20);
                   6:    v = (k < 32) || (k >= 48 && k < 80);
                   default: v = 1'b0;
               endcase
            1: case (s)
                   1:    v = (k < 8);
                   6:    v = (k < 8) || (k >= 12 && k < 20);
                   default: v = 1'b0;
               endcase
            default: case (s)
                   1:    v = (k < 40);
                   2:    v = (k < 26);
                   default: v = 1'b0;
               endcase
        endcase
        return v;
    endfunction

    task automatic pinChecks(input int s, input int k);
        if (s == 1) begin
            if (k == 1)  checkOutput("s1.d16.waitStart", 32'(st[0]), 32'd3);
            if (k == 16) checkOutput("s1.d16.waitEnd", 32'(st[0]), 32'd3);
            if (k == 17) checkOutput("s1.d16.firstStart", 32'(st[0]), 32'd1);
            if (k == 33) checkOutput("s1.d16.secondStart", 32'(st[0]), 32'd2);
            if (k == 40) checkOutput("s1.d16.tw7", 32'(tw[0]), 32'd7);
            if (k == 48) checkOutput("s1.d16.frameDone", 32'(fd[0]), 32'd1);
            if (k == 49) checkOutput("s1.d16.idleAgain", 32'(st[0]), 32'd0);
            if (k >= 9 && k <= 12) checkOutput("s1.d4.tw", 32'(tw[1]), 32'((k - 9) * 4));
            if (k == 1) checkOutput("s1.d1.state1", 32'(st[2]), 32'd3);
            if (k == 2) checkOutput("s1.d1.state2", 32'(st[2]), 32'd1);
            if (k == 3) checkOutput("s1.d1.state3", 32'(st[2]), 32'd2);
            if (k == 4) checkOutput("s1.d1.state4", 32'(st[2]), 32'd1);
        end
        if (s == 2) begin
            if (k == 48) checkOutput("s2.d16.ovContinuous", 32'(ov[0]), 32'd1);
            if (k == 49) checkOutput("s2.d16.firstAgain", 32'(st[0]), 32'd1);
            if (k == 64) checkOutput("s2.d16.firstEnd", 32'(st[0]), 32'd1);
            if (k == 65) checkOutput("s2.d16.drainSecond", 32'(st[0]), 32'd2);
            if (k == 79) checkOutput("s2.d16.noEarlyDone", 32'(fd[0]), 32'd0);
            if (k == 80) checkOutput("s2.d16.frameDone", 32'(fd[0]), 32'd1);
        end
        if (s == 3) begin
            if (k == 6)  checkOutput("s3.d16.errPulse", 32'(fe[0]), 32'd1);
            if (k == 7)  checkOutput("s3.d16.errCleared", 32'(fe[0]), 32'd0);
            if (k == 33) checkOutput("s3.d16.secondStart", 32'(st[0]), 32'd2);
            if (k == 49) checkOutput("s3.d16.idleAgain", 32'(st[0]), 32'd0);
        end
        if (s == 5) begin
            if (k == 1) checkOutput("s5.d16.restartWaiting", 32'(st[0]), 32'd3);
        end
        if (s == 6) begin
            if (k == 48) checkOutput("s6.d16.frameDone", 32'(fd[0]), 32'd1);
            if (k == 49) checkOutput("s6.d16.rearmWaiting", 32'(st[0]), 32'd3);
            if (k == 13) checkOutput("s6.d4.rearmWaiting", 32'(st[1]), 32'd3);
        end
    endtask

    task automatic applyStimulus(input int s, input int len);
        for (int k = 0; k < len; k++) begin
            @(posedge clk);
            #1;
            if (s == 4 && k == 20) begin
                checkOutput("s4.d16.preResetFirst", 32'(st[0]), 32'd1);
                rst_n = 1'b0;
                #1;
                checkOutput("s4.d16.resetState", 32'(st[0]), 32'd0);
                checkOutput("s4.d16.resetBusy", 32'(bz[0]), 32'd0);
                checkOutput("s4.d16.resetOutValid", 32'(ov[0]), 32'd0);
            end
            if (s == 4 && k == 23) rst_n = 1'b1;
            for (int i = 0; i < 3; i++) iv[i] = ivFor(s, i, k);
            pinChecks(s, k);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) iv[i] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.state", 32'(st[0]), 32'd0);
        checkOutput("reset.tw_idx", 32'(tw[0]), 32'd0);
        checkOutput("reset.busy", 32'(bz[0]), 32'd0);
        checkOutput("reset.out_valid", 32'(ov[0]), 32'd0);
        checkOutput("reset.frame_done", 32'(fd[0]), 32'd0);
        checkOutput("reset.frame_err", 32'(fe[0]), 32'd0);
        rst_n = 1'b1;
        applyStimulus(1, 60);
        applyStimulus(2, 90);
        applyStimulus(3, 60);
        applyStimulus(4, 30);
        applyStimulus(5, 60);
        applyStimulus(6, 110);
        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
